axi_wr_slave: RTL and testbench

//  AXI4 write-channel slave front end for the LPDDR controller. Accepts AW/W bursts from the
//  bus master and converts each beat into a single-cycle word write (addr/data/strobe) to the

---
 rtl/axi_wr_slave_if.sv | 31 +++
 rtl/axi_wr_slave.sv | 126 ++++++++++++
 tb/tb_axi_wr_slave.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_slave_if.sv
// axi_wr_slave_if: AXI4 write address, write data and write response channels.
interface axi_wr_slave_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_wr_slave.sv
// axi_wr_slave: AXI4 write slave turning each W beat into a one-cycle RAM word write.
// Define AXI_WR_RANGE_CHK_EN to reject beats addressed beyond the RAM with SLVERR.
module axi_wr_slave #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int MEM_AW = 16
) (
  input  logic                aclk,
  input  logic                areset,
  axi_wr_slave_if.slave       axi,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb
);
  localparam int STRB_W = DATA_W / 8;
  localparam int SW_LOG = $clog2(STRB_W);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, step, wb, nxt_addr;
  logic [7:0]          len_q, len_d, cnt_q, cnt_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic                err_q, err_d, nowr_q, nowr_d;
  logic                we_q, we_d;
  logic [MEM_AW-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   mdata_q, mdata_d;
  logic [STRB_W-1:0]   mstrb_q, mstrb_d;
  logic                aw_hs, w_hs, b_hs, last, oor, wrap_ok, bad_size;
  // Handshake outputs are forced low while reset is held so nothing is accepted mid-reset.
  assign axi.awready = state_q == IDLE && !areset;
  assign axi.wready  = state_q == DATA && !areset;
  assign axi.bvalid  = state_q == RESP && !areset;
  assign axi.bresp   = axi.bvalid ? {err_q, 1'b0} : 2'b00;
  assign axi.bid     = id_q;
  assign mem_we      = we_q;
  assign mem_addr    = maddr_q;
  assign mem_wdata   = mdata_q;
  assign mem_wstrb   = mstrb_q;
`ifdef AXI_WR_RANGE_CHK_EN
  assign oor = |(addr_q >> (MEM_AW + SW_LOG));
`else
  assign oor = 1'b0;
`endif
  always_comb begin
    aw_hs    = axi.awvalid & axi.awready;
    w_hs     = axi.wvalid & axi.wready;
    b_hs     = axi.bvalid & axi.bready;
    wrap_ok  = axi.awlen inside {8'd1, 8'd3, 8'd7, 8'd15};
    bad_size = int'(axi.awsize) > SW_LOG;
    step     = ADDR_W'(1) << size_q;
    wb       = (ADDR_W'(len_q) + ADDR_W'(1)) * step;
    nxt_addr = burst_q == 2'b00 ? addr_q :
               burst_q == 2'b10 ? ((addr_q & ~(wb - ADDR_W'(1))) | ((addr_q + step) & (wb - ADDR_W'(1)))) :
               addr_q + step;
    last     = cnt_q == len_q;
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    nowr_d   = nowr_q;
    we_d     = 1'b0;
    maddr_d  = maddr_q;
    mdata_d  = mdata_q;
    mstrb_d  = mstrb_q;
    if (aw_hs) begin
      id_d    = axi.awid;
      addr_d  = axi.awaddr;
      len_d   = axi.awlen;
      size_d  = axi.awsize;
      burst_d = axi.awburst == 2'b00 ? 2'b00 : (axi.awburst == 2'b10 && wrap_ok) ? 2'b10 : 2'b01;
      cnt_d   = '0;
      nowr_d  = bad_size;
      err_d   = bad_size || axi.awburst == 2'b11 || (axi.awburst == 2'b10 && !wrap_ok);
      state_d = DATA;
    end
    if (w_hs) begin
      we_d    = !nowr_q && !oor;
      maddr_d = addr_q[MEM_AW+SW_LOG-1:SW_LOG];
      mdata_d = axi.wdata;
      mstrb_d = axi.wstrb;
      addr_d  = nxt_addr;
      cnt_d   = cnt_q + 8'd1;
      err_d   = err_q || (axi.wlast != last) || oor;
      state_d = last ? RESP : DATA;
    end
    if (b_hs) state_d = IDLE;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      nowr_q  <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      mstrb_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      nowr_q  <= nowr_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mstrb_q <= mstrb_d;
    end
  end
endmodule

// File: tb/tb_axi_wr_slave.sv
// tb_axi_wr_slave: directed vector table, hand-built corner sequences and random bursts vs a reference model.
module tb_axi_wr_slave;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  always #5 aclk = ~aclk;
  axi_wr_slave_if #(.ID_W(4), .ADDR_W(32), .DATA_W(64)) bus ();
  axi_wr_slave #(.ID_W(4), .ADDR_W(32), .DATA_W(64), .MEM_AW(16)) dut (
    .aclk(aclk), .areset(areset), .axi(bus),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );
  typedef struct packed {logic [15:0] a; logic [63:0] d; logic [7:0] s;} wr_t;
  typedef struct {
    logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
    int wl; logic [31:0] strb; int n; logic [63:0] adr; logic [1:0] resp;
  } vec_t;
  wr_t got[$], exp_q[$];
  logic [63:0] bd[256];
  logic [7:0]  bs[256];
  logic        bl[256];
  int n_tests = 0, n_fail = 0;
  always @(negedge aclk) if (mem_we) got.push_back({mem_addr, mem_wdata, mem_wstrb});
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic wait_sig(input string nm, input int which, output bit ok);
    int t = 0;
    while (!(which == 0 ? bus.awready : which == 1 ? bus.wready : bus.bvalid) && t < 100) begin
      @(negedge aclk);
      t++;
    end
    ok = t < 100;
    if (!ok) chk({nm, "_timeout"}, 1, 0);
  endtask
  task automatic send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input int gaps,
                      input int bdelay, input logic [1:0] eresp);
    bit ok;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    wait_sig("aw", 0, ok);
    if (!ok) begin bus.awvalid = 1'b0; return; end
    @(negedge aclk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps > 0) repeat ($urandom_range(gaps, 0)) @(negedge aclk);
      bus.wvalid = 1'b1; bus.wdata = bd[i]; bus.wstrb = bs[i]; bus.wlast = bl[i];
      wait_sig("w", 1, ok);
      if (!ok) begin bus.wvalid = 1'b0; return; end
      @(negedge aclk);
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
    end
    wait_sig("b", 2, ok);
    if (!ok) return;
    for (int k = 0; k < bdelay; k++) begin
      chk("hold_bvalid", bus.bvalid, 1);
      chk("hold_bid", bus.bid, id);
      chk("hold_bresp", bus.bresp, eresp);
      chk("hold_awready", bus.awready, 0);
      @(negedge aclk);
    end
    chk("bid", bus.bid, id);
    chk("bresp", bus.bresp, eresp);
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    chk("awready_after_b", bus.awready, 1);
  endtask
  task automatic cmp_writes(input string nm);
    chk({nm, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk({nm, "_write"}, got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask
  task automatic model(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] burst, output logic [1:0] r);
    logic [31:0] step, wb, base, ba;
    bit wrap_ok, bad, err;
    wr_t w;
    step    = 32'd1 << size;
    wrap_ok = len == 1 || len == 3 || len == 7 || len == 15;
    bad     = size > 3;
    err     = bad || burst == 2'b11 || (burst == 2'b10 && !wrap_ok);
    wb      = (32'(len) + 32'd1) * step;
    base    = addr & ~(wb - 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      ba = burst == 2'b00 ? addr :
           (burst == 2'b10 && wrap_ok) ? base + ((addr - base + 32'(i) * step) % wb) :
           addr + 32'(i) * step;
      if (bl[i] != (i == int'(len))) err = 1;
      w = {ba[18:3], bd[i], bs[i]};
      if (!bad) exp_q.push_back(w);
    end
    r = err ? 2'b10 : 2'b00;
  endtask
  vec_t tv[12];
  logic [7:0] lens[5];
  initial begin
    logic [1:0] r;
    wr_t w;
    bit ok;
    tv[0]  = '{4'h5, 32'h100, 8'd3, 3'd3, 2'b01, 3, 32'hFFFFFFFF, 4, 64'h0023_0022_0021_0020, 2'b00};
    tv[1]  = '{4'h6, 32'h118, 8'd3, 3'd3, 2'b10, 3, 32'hFFFFFFFF, 4, 64'h0022_0021_0020_0023, 2'b00};
    tv[2]  = '{4'h7, 32'h040, 8'd2, 3'd3, 2'b00, 2, 32'h00FFF00F, 3, 64'h0000_0008_0008_0008, 2'b00};
    tv[3]  = '{4'h8, 32'h100, 8'd3, 3'd3, 2'b01, 2, 32'hFFFFFFFF, 4, 64'h0023_0022_0021_0020, 2'b10};
    tv[4]  = '{4'h9, 32'h200, 8'd1, 3'd2, 2'b01, 1, 32'h0000F00F, 2, 64'h0000_0000_0040_0040, 2'b00};
    tv[5]  = '{4'hA, 32'h100, 8'd1, 3'd3, 2'b11, 1, 32'hFFFFFFFF, 2, 64'h0000_0000_0021_0020, 2'b10};
    tv[6]  = '{4'hB, 32'h100, 8'd1, 3'd4, 2'b01, 1, 32'hFFFFFFFF, 0, 64'h0, 2'b10};
    tv[7]  = '{4'hC, 32'h118, 8'd2, 3'd3, 2'b10, 2, 32'hFFFFFFFF, 3, 64'h0000_0025_0024_0023, 2'b10};
    tv[8]  = '{4'hD, 32'h108, 8'd1, 3'd3, 2'b10, 1, 32'hFFFFFFFF, 2, 64'h0000_0000_0020_0021, 2'b00};
    tv[9]  = '{4'hE, 32'hFFFFFFF8, 8'd1, 3'd3, 2'b01, 1, 32'hFFFFFFFF, 2, 64'h0000_0000_0000_FFFF, 2'b00};
    tv[10] = '{4'hF, 32'h1238, 8'd0, 3'd3, 2'b01, 0, 32'h000000A5, 1, 64'h0000_0000_0000_0247, 2'b00};
    tv[11] = '{4'h0, 32'h008, 8'd0, 3'd3, 2'b01, -1, 32'hFFFFFFFF, 1, 64'h0000_0000_0000_0001, 2'b10};
    lens = '{8'd0, 8'd1, 8'd3, 8'd7, 8'd15};
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_bid", bus.bid, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_mem_addr", {mem_addr, mem_wdata, mem_wstrb}, 0);
    areset = 1'b0;
    @(negedge aclk);
    chk("awready_after_rst", bus.awready, 1);
    got.delete();
    foreach (tv[v]) begin
      for (int i = 0; i <= int'(tv[v].len); i++) begin
        bd[i] = {$urandom, $urandom};
        bs[i] = i < 4 ? tv[v].strb[8*i +: 8] : 8'hFF;
        bl[i] = i == tv[v].wl;
      end
      for (int i = 0; i < tv[v].n; i++) begin
        w = {tv[v].adr[16*i +: 16], bd[i], bs[i]};
        exp_q.push_back(w);
      end
      send(tv[v].id, tv[v].addr, tv[v].len, tv[v].size, tv[v].burst, 0, 0, tv[v].resp);
      cmp_writes($sformatf("vec%0d", v));
    end
    for (int i = 0; i < 2; i++) begin bd[i] = {$urandom, $urandom}; bs[i] = 8'hFF; bl[i] = i == 1; end
    model(32'h300, 8'd1, 3'd3, 2'b01, r);
    send(4'h3, 32'h300, 8'd1, 3'd3, 2'b01, 0, 5, r);
    cmp_writes("bready_hold");
    for (int i = 0; i < 8; i++) begin bd[i] = {$urandom, $urandom}; bs[i] = 8'hFF; bl[i] = i == 7; end
    bus.awid = 4'h2; bus.awaddr = 32'h400; bus.awlen = 8'd7; bus.awsize = 3'd3; bus.awburst = 2'b01;
    bus.awvalid = 1'b1;
    wait_sig("rst_aw", 0, ok);
    @(negedge aclk);
    bus.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.wvalid = 1'b1; bus.wdata = bd[i]; bus.wstrb = bs[i]; bus.wlast = 1'b0;
      wait_sig("rst_w", 1, ok);
      @(negedge aclk);
    end
    bus.wdata = bd[2];
    areset = 1'b1;
    #1;
    chk("midrst_wready", bus.wready, 0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_awready", bus.awready, 1);
    bus.wvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("midrst_bvalid", bus.bvalid, 0);
      chk("midrst_no_we", mem_we, 0);
    end
    w = {16'h0080, bd[0], 8'hFF}; exp_q.push_back(w);
    w = {16'h0081, bd[1], 8'hFF}; exp_q.push_back(w);
    cmp_writes("midrst");
    for (int t = 0; t < 40; t++) begin
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      bit good;
      addr  = $urandom_range(3, 0) == 0 ? $urandom : 32'($urandom_range(32'h3FFF, 0));
      len   = $urandom_range(1, 0) == 0 ? lens[$urandom_range(4, 0)] : 8'($urandom_range(20, 0));
      size  = 3'($urandom_range(4, 0));
      burst = 2'($urandom_range(3, 0));
      good  = $urandom_range(7, 0) != 0;
      for (int i = 0; i <= int'(len); i++) begin
        bd[i] = {$urandom, $urandom};
        bs[i] = 8'($urandom);
        bl[i] = good ? i == int'(len) : 1'($urandom_range(1, 0));
      end
      model(addr, len, size, burst, r);
      send(4'($urandom), addr, len, size, burst, 2, $urandom_range(2, 0), r);
      cmp_writes($sformatf("rand%0d", t));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
